cam_pattern_emu: RTL and testbench

- Synthesizable emulator of a DVP camera sensor: the transmitter end of the camera link.
- Generates VSYNC_cam/HREF_cam/data_cam byte streams and a conf_done flag that the camera receiver path consumes.
- Lets the dual-cam USB3 datapath be brought up and regression-tested without sensors attached.
- Emits RGB565 pixels, high byte first, two bytes per pixel, one byte per clk cycle; the receiver samples on the same clk used as PCLK_cam.

---
 rtl/cam_pattern_emu.sv | 164 ++++++++++++++++
 tb/tb_cam_pattern_emu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cam_pattern_emu.sv
// DVP camera sensor emulator: produces VSYNC/HREF/byte streams of RGB565 test
// patterns so the receiver path can be exercised without a real sensor.
module cam_pattern_emu #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int CONF_DELAY  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        on_off_cam,
    input  logic [1:0]  pattern_sel,
    output logic        conf_done,
    output logic        VSYNC_cam,
    output logic        HREF_cam,
    output logic [7:0]  data_cam,
    output logic [15:0] frame_cnt
);

    localparam int LINE_LEN    = 2*H_ACTIVE + H_BLANK;
    localparam int FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int COL_W       = $clog2(LINE_LEN + 1);
    localparam int ROW_W       = $clog2(FRAME_LINES + 1);
    localparam int CNT_W       = $clog2(CONF_DELAY + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
    localparam logic [COL_W-1:0] HREF_END = COL_W'(2*H_ACTIVE);
    localparam logic [ROW_W-1:0] VS_LAST  = ROW_W'(VSYNC_LINES - 1);
    localparam logic [ROW_W-1:0] VB_LAST  = ROW_W'(V_BACK - 1);
    localparam logic [ROW_W-1:0] VA_LAST  = ROW_W'(V_ACTIVE - 1);
    localparam logic [ROW_W-1:0] VF_LAST  = ROW_W'(V_FRONT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONF_DELAY - 1);

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_CONF   = 3'd1;
    localparam logic [2:0] S_VSYNC  = 3'd2;
    localparam logic [2:0] S_VBACK  = 3'd3;
    localparam logic [2:0] S_ACTIVE = 3'd4;
    localparam logic [2:0] S_VFRONT = 3'd5;

    logic [2:0]       state, state_n;
    logic [COL_W-1:0] col, col_n;
    logic [ROW_W-1:0] row, row_n, row_last;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             conf_n;
    logic [15:0]      frame_n;
    logic [1:0]       psel, psel_n;
    logic [15:0]      fval, fval_n;
    logic             line_end;
    logic             href_n;
    logic [15:0]      x, y, pix;
    logic [7:0]       byte_n;

    // Next-state logic; every output register is derived from these next values
    // so the outputs always agree with the state register after the edge.
    always_comb begin
        state_n  = state;
        col_n    = '0;
        row_n    = '0;
        cnt_n    = '0;
        conf_n   = conf_done;
        frame_n  = frame_cnt;
        psel_n   = psel;
        fval_n   = fval;
        line_end = (col == COL_LAST);

        case (state)
            S_VBACK:  row_last = VB_LAST;
            S_ACTIVE: row_last = VA_LAST;
            S_VFRONT: row_last = VF_LAST;
            default:  row_last = VS_LAST;
        endcase

        if (!on_off_cam) begin
            state_n = S_OFF;
            conf_n  = 1'b0;
        end else begin
            case (state)
                S_OFF: state_n = S_CONF;
                S_CONF: begin
                    if (conf_done) begin
                        state_n = S_VSYNC;
                        psel_n  = pattern_sel;
                        fval_n  = frame_cnt;
                    end else if (cnt == CNT_LAST) begin
                        conf_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    col_n = line_end ? '0 : col + 1'b1;
                    row_n = row;
                    if (line_end) begin
                        if (row == row_last) begin
                            row_n = '0;
                            case (state)
                                S_VSYNC:  state_n = S_VBACK;
                                S_VBACK:  state_n = S_ACTIVE;
                                S_ACTIVE: state_n = S_VFRONT;
                                S_VFRONT: begin
                                    state_n = S_VSYNC;
                                    frame_n = frame_cnt + 16'd1;
                                    psel_n  = pattern_sel;
                                    fval_n  = frame_cnt + 16'd1;
                                end
                                default:  state_n = S_OFF;
                            endcase
                        end else begin
                            row_n = row + 1'b1;
                        end
                    end
                end
            endcase
        end

        // Two bytes per pixel, so the pixel index is the column divided by two.
        x = 16'(col_n[COL_W-1:1]);
        y = 16'(row_n);
        case (psel)
            2'd0:    pix = x;
            2'd1:    pix = y;
            2'd2:    pix = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
            default: pix = fval;
        endcase

        href_n = (state_n == S_ACTIVE) && (col_n < HREF_END);
        byte_n = 8'h00;
        if (href_n)
            byte_n = col_n[0] ? pix[7:0] : pix[15:8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_OFF;
            col       <= '0;
            row       <= '0;
            cnt       <= '0;
            psel      <= '0;
            fval      <= '0;
            conf_done <= 1'b0;
            VSYNC_cam <= 1'b0;
            HREF_cam  <= 1'b0;
            data_cam  <= 8'h00;
            frame_cnt <= 16'h0000;
        end else begin
            state     <= state_n;
            col       <= col_n;
            row       <= row_n;
            cnt       <= cnt_n;
            psel      <= psel_n;
            fval      <= fval_n;
            conf_done <= conf_n;
            VSYNC_cam <= (state_n == S_VSYNC);
            HREF_cam  <= href_n;
            data_cam  <= byte_n;
            frame_cnt <= frame_n;
        end
    end

endmodule

// File: tb/tb_cam_pattern_emu.sv
// Bench for cam_pattern_emu: directed timing points plus randomized enable,
// reset and pattern activity compared each cycle against a timeline model.
module tb_cam_pattern_emu;

    localparam int HA = 4, HB = 3, VA = 2, VS = 1, VB = 1, VF = 1, CD = 5;
    localparam int LL = 2*HA + HB;
    localparam int FC = (VS + VB + VA + VF) * LL;

    logic        clk = 1'b0;
    logic        rst;
    logic        on_off_cam;
    logic [1:0]  pattern_sel;
    logic        conf_done;
    logic        VSYNC_cam;
    logic        HREF_cam;
    logic [7:0]  data_cam;
    logic [15:0] frame_cnt;

    cam_pattern_emu #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VS),
        .V_BACK(VB), .V_FRONT(VF), .CONF_DELAY(CD)
    ) dut (
        .clk(clk), .rst(rst), .on_off_cam(on_off_cam), .pattern_sel(pattern_sel),
        .conf_done(conf_done), .VSYNC_cam(VSYNC_cam), .HREF_cam(HREF_cam),
        .data_cam(data_cam), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Timeline model: outputs follow from the cycle count since enable.
    bit          m_en = 1'b0;
    int          m_t;
    logic [15:0] m_base, m_fcnt = 16'h0, m_fval = 16'h0;
    logic [1:0]  m_psel = 2'd0;
    logic        m_conf, m_vs, m_href;
    logic [7:0]  m_data;
    int          s_, f_, p_, ln, c_, ay;
    logic [15:0] xv, yv, pix;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        m_conf = 1'b0; m_vs = 1'b0; m_href = 1'b0; m_data = 8'h00;
        if (rst) begin
            m_en   = 1'b0;
            m_fcnt = 16'h0;
        end else if (!on_off_cam) begin
            m_en = 1'b0;
        end else begin
            if (!m_en) begin
                m_en = 1'b1; m_t = 0; m_base = m_fcnt;
            end else begin
                m_t++;
            end
            m_conf = (m_t >= CD);
            if (m_t >= CD + 1) begin
                s_ = m_t - CD - 1;
                f_ = s_ / FC;
                p_ = s_ % FC;
                ln = p_ / LL;
                c_ = p_ % LL;
                m_fcnt = m_base + 16'(f_);
                if (p_ == 0) begin
                    m_psel = pattern_sel;
                    m_fval = m_fcnt;
                end
                m_vs = (ln < VS);
                ay = ln - VS - VB;
                if (ay >= 0 && ay < VA && c_ < 2*HA) begin
                    m_href = 1'b1;
                    xv = 16'(c_ / 2);
                    yv = 16'(ay);
                    case (m_psel)
                        2'd0:    pix = xv;
                        2'd1:    pix = yv;
                        2'd2:    pix = (((xv >> 3) ^ (yv >> 3)) & 16'd1) != 0 ? 16'hFFFF : 16'h0000;
                        default: pix = m_fval;
                    endcase
                    m_data = (c_ % 2 == 0) ? pix[15:8] : pix[7:0];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("conf_done", 16'(conf_done), 16'(m_conf));
            check("VSYNC_cam", 16'(VSYNC_cam), 16'(m_vs));
            check("HREF_cam",  16'(HREF_cam),  16'(m_href));
            check("data_cam",  16'(data_cam),  16'(m_data));
            check("frame_cnt", frame_cnt,      m_fcnt);
        end
    end

    logic [7:0] line0 [8];
    int rst_left = 0, off_left = 0, waited;

    initial begin
        line0 = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
        rst = 1'b1; on_off_cam = 1'b0; pattern_sel = 2'd0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_conf", 16'(conf_done), 16'h0);
        check("reset_frame", frame_cnt, 16'h0);

        // Power-up timeline; cycle 0 is the edge that first samples on_off_cam=1.
        rst = 1'b0; on_off_cam = 1'b1;
        for (int cyc = 0; cyc <= 110; cyc++) begin
            @(negedge clk);
            if (cyc == 4)  check("conf_early", 16'(conf_done), 16'h0);
            if (cyc == 5)  check("conf_at5", 16'(conf_done), 16'h1);
            if (cyc == 5)  check("vsync_pre", 16'(VSYNC_cam), 16'h0);
            if (cyc == 6)  check("vsync_rise", 16'(VSYNC_cam), 16'h1);
            if (cyc == 16) check("vsync_last", 16'(VSYNC_cam), 16'h1);
            if (cyc == 17) check("vsync_fall", 16'(VSYNC_cam), 16'h0);
            if (cyc == 27) check("href_pre", 16'(HREF_cam), 16'h0);
            if (cyc >= 28 && cyc <= 35) begin
                check("href_line0", 16'(HREF_cam), 16'h1);
                check("data_xramp", 16'(data_cam), 16'(line0[cyc-28]));
            end
            if (cyc == 36) check("href_blank", 16'(HREF_cam), 16'h0);
            if (cyc == 36) check("data_blank", 16'(data_cam), 16'h0);
            if (cyc == 30) pattern_sel = 2'd1;
            if (cyc == 60) check("frame_before", frame_cnt, 16'h0);
            if (cyc == 61) check("frame_inc", frame_cnt, 16'h1);
            if (cyc == 61) check("vsync_second", 16'(VSYNC_cam), 16'h1);
            if (cyc == 94) check("yramp_hi", 16'(data_cam), 16'h00);
            if (cyc == 95) check("yramp_lo", 16'(data_cam), 16'h01);
            if (cyc == 97) begin
                check("href_before_off", 16'(HREF_cam), 16'h1);
                on_off_cam = 1'b0;
            end
            if (cyc == 98) begin
                check("off_href", 16'(HREF_cam), 16'h0);
                check("off_data", 16'(data_cam), 16'h0);
                check("off_conf", 16'(conf_done), 16'h0);
                check("off_frame_held", frame_cnt, 16'h1);
            end
            if (cyc == 99)  on_off_cam = 1'b1;
            if (cyc == 104) check("reconf_early", 16'(conf_done), 16'h0);
            if (cyc == 105) check("reconf_at5", 16'(conf_done), 16'h1);
        end

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = 1'b0; on_off_cam = 1'b1;
            if (rst_left > 0) begin
                rst = 1'b1; rst_left--;
            end else if ($urandom_range(0, 1499) == 0) begin
                rst = 1'b1; rst_left = $urandom_range(1, 8);
            end
            if (off_left > 0) begin
                on_off_cam = 1'b0; off_left--;
            end else if ($urandom_range(0, 699) == 0) begin
                on_off_cam = 1'b0; off_left = $urandom_range(1, 20);
            end
            if ($urandom_range(0, 19) == 0) pattern_sel = 2'($urandom_range(0, 3));
        end

        // Reset during an active line, then hold reset with the sensor enabled.
        rst = 1'b0; on_off_cam = 1'b1;
        waited = 0;
        while (HREF_cam !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("href_seen_timeout", 16'(HREF_cam), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_href", 16'(HREF_cam), 16'h0);
        check("rst_frame", frame_cnt, 16'h0);
        repeat (8) @(negedge clk);
        check("rst_hold_conf", 16'(conf_done), 16'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
